// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// opcode values, FSM state encoding and the round-robin pick.
package alu_pkg;

  localparam int unsigned ADD  = 0;
  localparam int unsigned SUB  = 1;
  localparam int unsigned AND  = 2;
  localparam int unsigned OR   = 3;
  localparam int unsigned SRL  = 4;
  localparam int unsigned SRA  = 5;
  localparam int unsigned SLL  = 6;
  localparam int unsigned SLT  = 7;
  localparam int unsigned SLTU = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // On a tie the requester that did not win last time is picked.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    logic id;
    case (valid)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      2'b11:   id = ~last;
      default: id = 1'b0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the ALU arbiter: two requesters in, one result out.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b1;
  logic [OP_W-1:0]   req_op0;
  logic [OP_W-1:0]   req_op1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_out;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU: nine integer operations, anything above SLTU flags err
// and yields zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              err
);

  logic [4:0]  shamt;
  int unsigned opc;

  assign shamt = b[4:0];

  always_comb begin
    opc = 32'(op);
    y   = '0;
    err = 1'b0;
    case (opc)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      SRL:     y = a >> shamt;
      SRA:     y = $unsigned($signed(a) >>> shamt);
      SLL:     y = a << shamt;
      SLT:     y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    y = {{(DATA_W-1){1'b0}}, (a < b)};
      default: err = 1'b1;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: one operation in
// flight at a time, result held until the consumer takes it.
//
// state   | meaning
// IDLE    | granting; req_ready one-hot on the winner when any request is valid
// EXEC    | operands latched, ALU result registered at end of cycle
// RESP    | rsp_valid high, outputs held until rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt_id;
  logic [1:0]        ready;
  logic              accept;

  logic              id_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;

  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_out_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;
  logic              alu_err;

  // rst_n gates ready so nothing is offered while reset is held.
  always_comb begin
    gnt_id = rr_pick(bus.req_valid, last_grant);
    ready  = 2'b00;
    if (state == ST_IDLE && (|bus.req_valid) && rst_n)
      ready = gnt_id ? 2'b10 : 2'b01;
  end

  assign accept = |ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_id_q   <= 1'b0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id_q       <= gnt_id;
            last_grant <= gnt_id;
            a_q        <= gnt_id ? bus.req_a1  : bus.req_a0;
            b_q        <= gnt_id ? bus.req_b1  : bus.req_b0;
            op_q       <= gnt_id ? bus.req_op1 : bus.req_op0;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_id_q   <= id_q;
          rsp_out_q  <= alu_y;
          rsp_zero_q <= alu_zero;
          rsp_err_q  <= alu_err;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .y    (alu_y),
    .zero (alu_zero),
    .err  (alu_err)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
